// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dec_q, dec_d;
  logic             pgt_q, pgt_d;
  logic             plt_q, plt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic slice_gt;
  logic slice_lt;
  logic fin;

  // The operand MSB always holds the bit currently being evaluated.
  assign slice_gt = a_q[WIDTH-1] & ~b_q[WIDTH-1];
  assign slice_lt = ~a_q[WIDTH-1] & b_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    pgt_d   = pgt_q;
    plt_d   = plt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(WIDTH - 1);
          dec_d   = 1'b0;
          pgt_d   = 1'b0;
          plt_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        a_d   = {a_q[WIDTH-2:0], 1'b0};
        b_d   = {b_q[WIDTH-2:0], 1'b0};
        idx_d = idx_q - IDX_W'(1);
        if (!dec_q && (slice_gt || slice_lt)) begin
          dec_d = 1'b1;
          pgt_d = slice_gt;
          plt_d = slice_lt;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        fin = (idx_q == '0) || dec_d;
`else
        fin = (idx_q == '0);
`endif
        if (fin) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          gt_d    = pgt_d;
          lt_d    = plt_d;
          eq_d    = ~dec_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      pgt_q   <= 1'b0;
      plt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      pgt_q   <= pgt_d;
      plt_q   <= plt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule
